// File: rtl/gpio_bank.sv
// Memory-mapped GPIO bank: per-pin direction, synchronised inputs, atomic set/clear/toggle
// and edge-capture interrupts. Define GPIO_DEBOUNCE_EN to add a per-pin input debouncer.
module gpio_bank #(
    parameter logic [31:0] ADDR_BASE       = 32'h0000_0100,
    parameter int          N_PINS          = 8,
    parameter int          SYNC_STAGES     = 2,
    parameter int          DEBOUNCE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              wen,
    input  logic [31:0]       addr,
    input  logic [31:0]       data_i,
    output logic [31:0]       data_o,
    input  logic [N_PINS-1:0] in,
    output logic [N_PINS-1:0] out,
    output logic [N_PINS-1:0] oe,
    output logic              irq
);

    localparam logic [3:0] IDX_IN   = 4'h0;
    localparam logic [3:0] IDX_OUT  = 4'h1;
    localparam logic [3:0] IDX_DIR  = 4'h2;
    localparam logic [3:0] IDX_SET  = 4'h3;
    localparam logic [3:0] IDX_CLR  = 4'h4;
    localparam logic [3:0] IDX_TGL  = 4'h5;
    localparam logic [3:0] IDX_RISE = 4'h6;
    localparam logic [3:0] IDX_FALL = 4'h7;
    localparam logic [3:0] IDX_IEN  = 4'h8;
    localparam logic [3:0] IDX_ST   = 4'h9;

    logic              hit;
    logic [3:0]        idx;
    logic              wr;
    logic [N_PINS-1:0] wdata;
    logic [N_PINS-1:0] sync;
    logic [N_PINS-1:0] level;
    logic [N_PINS-1:0] cap;
    logic [N_PINS-1:0] rd;
    logic              unused_bits;

    logic [N_PINS-1:0] sync_q [SYNC_STAGES];
    logic [N_PINS-1:0] sync_d [SYNC_STAGES];
    logic [N_PINS-1:0] out_q, out_d, dir_q, dir_d, rise_q, rise_d, fall_q, fall_d;
    logic [N_PINS-1:0] ien_q, ien_d, st_q, st_d, prev_q, prev_d;

    assign hit         = (addr[31:6] == ADDR_BASE[31:6]);
    assign idx         = addr[5:2];
    assign wr          = en && wen && hit;
    assign wdata       = data_i[N_PINS-1:0];
    assign unused_bits = ^{addr[1:0], data_i};

    always_comb begin
        sync_d[0] = in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic [15:0]       cnt_q [N_PINS];
    logic [15:0]       cnt_d [N_PINS];
    logic [N_PINS-1:0] filt_q, filt_d;

    // Counter tracks consecutive cycles sync disagrees with the filtered value.
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < N_PINS; i++) begin
            cnt_d[i] = '0;
            if (sync[i] != filt_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    filt_d[i] = sync[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= '0;
            for (int i = 0; i < N_PINS; i++) cnt_q[i] <= '0;
        end else begin
            filt_q <= filt_d;
            for (int i = 0; i < N_PINS; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign level = filt_q;
`else
    assign level = sync;
`endif

    // Capture uses the enables as they stood before this edge, so RISE/FALL writes
    // only affect edges detected from the next cycle on; a new edge beats a W1C.
    always_comb begin
        out_d  = out_q;
        dir_d  = dir_q;
        rise_d = rise_q;
        fall_d = fall_q;
        ien_d  = ien_q;
        prev_d = level;
        cap    = (level & ~prev_q & rise_q) | (~level & prev_q & fall_q);
        st_d   = st_q | cap;
        if (wr) begin
            case (idx)
                IDX_OUT:  out_d  = wdata;
                IDX_DIR:  dir_d  = wdata;
                IDX_SET:  out_d  = out_q | wdata;
                IDX_CLR:  out_d  = out_q & ~wdata;
                IDX_TGL:  out_d  = out_q ^ wdata;
                IDX_RISE: rise_d = wdata;
                IDX_FALL: fall_d = wdata;
                IDX_IEN:  ien_d  = wdata;
                IDX_ST:   st_d   = (st_q & ~wdata) | cap;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            out_q  <= '0;
            dir_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
            ien_q  <= '0;
            st_q   <= '0;
            prev_q <= '0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
            out_q  <= out_d;
            dir_q  <= dir_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            ien_q  <= ien_d;
            st_q   <= st_d;
            prev_q <= prev_d;
        end
    end

    always_comb begin
        rd = '0;
        if (en && hit) begin
            case (idx)
                IDX_IN:   rd = level;
                IDX_OUT:  rd = out_q;
                IDX_DIR:  rd = dir_q;
                IDX_RISE: rd = rise_q;
                IDX_FALL: rd = fall_q;
                IDX_IEN:  rd = ien_q;
                IDX_ST:   rd = st_q;
                default:  rd = '0;
            endcase
        end
    end

    always_comb begin
        data_o             = '0;
        data_o[N_PINS-1:0] = rd;
    end

    assign out = out_q;
    assign oe  = dir_q;
    assign irq = |(st_q & ien_q);

endmodule
